dsp_delay_ctrl: RTL and testbench
=================================

Name: dsp_delay_ctrl

Overview:
Sequencer that sits directly upstream of the DSP48-based delay counter (dsp_delay). It accepts delay requests over a valid/ready handshake and buffers them in a small FIFO. For each request it pulses the counter's reset, drives the 16-bit delay value and count-enable, waits for count-reached, then emits a one-cycle fire pulse with a request tag. It serialises triggered-delay requests so the single DSP counter is reused safely.

Parameters:
FIFO_DEPTH, 4, pending-request entries; power of 2, 2..16.
TAG_W, 4, width of the request tag carried to the fire output.
RST_LATENCY, 2, cycles from dly_rst_o rising to the counter being loaded (0/1/2 = NONE/SINGLE/DOUBLE pipelining in the counter).
TIMEOUT_MARGIN, 8, extra cycles beyond the delay before a timeout abort (used only with the optional feature).

Ports:
fast_clk_i  in  1  sole clock.
fast_rst_n_i  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  FIFO not full.
req_delay_i  in  16  delay in enabled cycles.
req_tag_i  in  TAG_W  opaque tag.
dly_rst_o  out  1  to counter fast_rst_i.
dly_en_o  out  1  to counter count_enable_i.
dly_val_o  out  16  to counter delay_i.
dly_reached_i  in  1  from counter count_reached_o.
fire_o  out  1  one-cycle pulse at delay expiry.
fire_tag_o  out  TAG_W  tag of the fired request; valid with fire_o.
busy_o  out  1  FSM not IDLE, or FIFO non-empty.
abort_o  out  1  one-cycle pulse on timeout (optional feature only; otherwise tied 0).

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE. req_ready_o goes 1 on the first clock after reset deasserts. Reset mid-operation discards all pending requests and produces no fire.
- FIFO: a push occurs when req_valid_i && req_ready_o. req_ready_o = !full.
  - Push and pop in the same cycle when full: the push is refused because ready is already low.
  - Push and pop in the same cycle when empty: not possible, since a pop needs a registered entry. The new entry is visible to the FSM the next cycle.
- FSM states: IDLE, ARM, LOAD, COUNT, FIRE.
- IDLE:
  - If the FIFO is non-empty, pop the head into the cur_delay/cur_tag registers.
  - If cur_delay == 0, go to FIRE; no counter activity takes place.
  - Otherwise go to ARM.
- ARM: dly_rst_o=1 for exactly one cycle; dly_val_o=cur_delay. Then go to LOAD.
- LOAD:
  - Wait RST_LATENCY+1 cycles with dly_en_o=0 and dly_rst_o=0, so the counter's C/P registers load.
  - dly_val_o is held stable from ARM through the end of COUNT.
- COUNT: dly_en_o=1. On dly_reached_i=1, drop dly_en_o in the same cycle (combinational gate) and go to FIRE.
- FIRE: fire_o=1 and fire_tag_o=cur_tag for one cycle, then go to IDLE. A queued request starts ARM no earlier than one cycle after FIRE.
- dly_reached_i outside COUNT is ignored. This covers spurious matches during LOAD and the counter's autoreset match.
- End-to-end latency, request accepted into an empty idle block until fire_o: 1 (FIFO) + 1 (IDLE) + 1 (ARM) + RST_LATENCY+1 (LOAD) + D + counter pipeline + 1 (FIRE) cycles.
  - The bench checks this against the counter model with D = req_delay_i.
- Delays are 16-bit unsigned with no wrap; 0xFFFF is legal.
- dly_val_o is 0 in IDLE.

Optional Feature:
- Macro DSP_DELAY_CTRL_TIMEOUT_EN.
- Defined:
  - A 17-bit watchdog loads cur_delay + TIMEOUT_MARGIN when COUNT is entered and decrements while in COUNT.
  - If it reaches 0 without dly_reached_i: abort_o pulses for one cycle, dly_en_o drops, fire_o is not asserted, and the FSM goes to IDLE; that request is dropped.
  - If dly_reached_i and expiry occur in the same cycle, the reached indication wins.
- Undefined: no watchdog logic; abort_o is tied 0; COUNT waits indefinitely.

Decomposition:
- Shared header/package: FSM state encodings (ST_IDLE..ST_FIRE, 3-bit) and a DLY_W=16 width constant, shared with the counter instantiation.
- One sub-module: dsp_delay_req_fifo, a synchronous FIFO (FIFO_DEPTH x (16+TAG_W)) with full/empty flags, async active-low reset, and registered output.

Test Plan:
- Single request, delay=5, tag=3, RST_LATENCY=2, counter model attached -> exactly one fire_o, fire_tag_o=3, at the computed latency; dly_en_o high for exactly 5 cycles plus counter pipeline.
- Four back-to-back requests (delays 1, 2, 3, 4; tags 0..3), fifth while full -> req_ready_o=0 while full; fires arrive in order with tags 0..3; the fifth is accepted after the first pop.
- delay=0, tag=7 -> fire_o with tag 7 two cycles after acceptance; dly_rst_o and dly_en_o never assert.
- Reset asserted during COUNT with two requests queued -> all outputs 0 asynchronously; no fire after release; FIFO empty.
- Spurious dly_reached_i pulse during LOAD -> ignored; fire occurs only on the genuine match.
- With DSP_DELAY_CTRL_TIMEOUT_EN, TIMEOUT_MARGIN=8, delay=10, counter stalled -> abort_o pulses 18 cycles after COUNT entry; no fire_o; the next queued request proceeds normally.

Source files
------------

// File: rtl/dsp_delay_ctrl_pkg.sv
// Shared definitions for the DSP delay sequencer: FSM state encoding and delay width.
package dsp_delay_ctrl_pkg;

    localparam int unsigned DLY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COUNT = 3'd3,
        ST_FIRE  = 3'd4
    } state_t;

endpackage

// File: rtl/dsp_delay_req_fifo.sv
// Pending-request FIFO for dsp_delay_ctrl: register storage, full/empty from an occupancy count.
module dsp_delay_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsp_delay_ctrl.sv
// Serialising sequencer for the shared DSP48 delay counter: queue, arm, load, count, fire.
// Optional watchdog abort enabled by defining DSP_DELAY_CTRL_TIMEOUT_EN.
module dsp_delay_ctrl
    import dsp_delay_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned RST_LATENCY    = 2,
    parameter int unsigned TIMEOUT_MARGIN = 8
) (
    input  logic             fast_clk_i,
    input  logic             fast_rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DLY_W-1:0] req_delay_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             dly_rst_o,
    output logic             dly_en_o,
    output logic [DLY_W-1:0] dly_val_o,
    input  logic             dly_reached_i,
    output logic             fire_o,
    output logic [TAG_W-1:0] fire_tag_o,
    output logic             busy_o,
    output logic             abort_o
);

    localparam logic [3:0] LOAD_LAST = 4'(RST_LATENCY);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 2..16");
    end
    if (RST_LATENCY > 2 || TIMEOUT_MARGIN > 65536) begin : g_bad_timing
        $error("RST_LATENCY must be 0..2 and TIMEOUT_MARGIN must fit the 17-bit watchdog");
    end

    state_t                   state;
    state_t                   state_nxt;
    logic                     rdy_q;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [DLY_W+TAG_W-1:0]   head;
    logic [DLY_W-1:0]         head_delay;
    logic [TAG_W-1:0]         head_tag;
    logic [DLY_W-1:0]         cur_delay;
    logic [TAG_W-1:0]         cur_tag;
    logic [3:0]               load_cnt;
    logic                     load_done;
    logic                     expired;

    // Ready is held low through reset and the first edge after release.
    assign req_ready_o = rdy_q && !full;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == ST_IDLE) && !empty;
    assign head_delay  = head[DLY_W+TAG_W-1:TAG_W];
    assign head_tag    = head[TAG_W-1:0];
    assign load_done   = (load_cnt == LOAD_LAST);

    dsp_delay_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DLY_W + TAG_W)
    ) u_fifo (
        .clk   (fast_clk_i),
        .rst_n (fast_rst_n_i),
        .push  (push),
        .din   ({req_delay_i, req_tag_i}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            rdy_q     <= 1'b0;
            cur_delay <= '0;
            cur_tag   <= '0;
            load_cnt  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (pop) begin
                cur_delay <= head_delay;
                cur_tag   <= head_tag;
            end
            if (state == ST_ARM) begin
                load_cnt <= '0;
            end else if (state == ST_LOAD) begin
                load_cnt <= load_cnt + 4'd1;
            end
        end
    end

`ifdef DSP_DELAY_CTRL_TIMEOUT_EN
    logic [16:0] wd;

    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            wd <= '0;
        end else if (state == ST_LOAD && load_done) begin
            wd <= {1'b0, cur_delay} + 17'(TIMEOUT_MARGIN);
        end else if (state == ST_COUNT && wd != '0) begin
            wd <= wd - 17'd1;
        end
    end

    assign expired = (state == ST_COUNT) && (wd == '0);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = (head_delay == '0) ? ST_FIRE : ST_ARM;
            ST_ARM:   state_nxt = ST_LOAD;
            ST_LOAD:  if (load_done) state_nxt = ST_COUNT;
            // A reached indication beats a coincident watchdog expiry.
            ST_COUNT: begin
                if (dly_reached_i) begin
                    state_nxt = ST_FIRE;
                end else if (expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FIRE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dly_rst_o  = (state == ST_ARM);
        dly_en_o   = (state == ST_COUNT) && !dly_reached_i && !expired;
        dly_val_o  = (state == ST_ARM || state == ST_LOAD || state == ST_COUNT) ? cur_delay : '0;
        fire_o     = (state == ST_FIRE);
        fire_tag_o = (state == ST_FIRE) ? cur_tag : '0;
        busy_o     = (state != ST_IDLE) || !empty;
        abort_o    = (state == ST_COUNT) && expired && !dly_reached_i;
    end

endmodule

// File: tb/tb_dsp_delay_ctrl.sv
// Directed bench for dsp_delay_ctrl with a simple counter model on the dly_* interface.
// Timeout scenario runs only when DSP_DELAY_CTRL_TIMEOUT_EN is defined.
module tb_dsp_delay_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_delay;
    logic [3:0]  req_tag;
    logic        dly_rst;
    logic        dly_en;
    logic [15:0] dly_val;
    logic        dly_reached;
    logic        fire;
    logic [3:0]  fire_tag;
    logic        busy;
    logic        abort_sig;

    logic        spur;
    logic        stall;
    logic [15:0] cnt = '0;
    logic [3:0]  fire_q [$];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dsp_delay_ctrl #(
        .FIFO_DEPTH     (4),
        .TAG_W          (4),
        .RST_LATENCY    (2),
        .TIMEOUT_MARGIN (8)
    ) dut (
        .fast_clk_i    (clk),
        .fast_rst_n_i  (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_delay_i   (req_delay),
        .req_tag_i     (req_tag),
        .dly_rst_o     (dly_rst),
        .dly_en_o      (dly_en),
        .dly_val_o     (dly_val),
        .dly_reached_i (dly_reached),
        .fire_o        (fire),
        .fire_tag_o    (fire_tag),
        .busy_o        (busy),
        .abort_o       (abort_sig)
    );

    // Counter model: cleared by dly_rst, counts enabled cycles, match is one cycle behind the count.
    always_ff @(posedge clk) begin
        if (dly_rst) cnt <= '0;
        else if (dly_en) cnt <= cnt + 16'd1;
    end
    assign dly_reached = spur | (!stall && (cnt == dly_val));

    always @(negedge clk) begin
        if (fire) fire_q.push_back(fire_tag);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_req(input logic [15:0] d, input logic [3:0] t);
        @(negedge clk);
        check("push_ready", req_ready, 1);
        req_valid = 1'b1;
        req_delay = d;
        req_tag   = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_fire(input int spur_at, input logic [15:0] d, output int edges,
                            output int en_c, output int rst_c, output int val_bad,
                            output logic [3:0] tag);
        edges = 0; en_c = 0; rst_c = 0; val_bad = 0; tag = 'x;
        while (edges < 300) begin
            if (fire) begin
                tag = fire_tag;
                break;
            end
            if (dly_en) en_c++;
            if (dly_rst) rst_c++;
            if ((dly_en || dly_rst) && dly_val !== d) val_bad++;
            spur = (edges == spur_at);
            @(posedge clk);
            #1 edges++;
        end
        spur = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1);
    end

    initial begin
        int edges, en_c, rst_c, val_bad, waited;
        logic [3:0] tag;

        rst_n = 1'b0; req_valid = 1'b0; req_delay = '0; req_tag = '0;
        spur = 1'b0; stall = 1'b0;

        #12;
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fire", fire, 0);
        check("rst_dly_en", dly_en, 0);
        check("rst_dly_rst", dly_rst, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready_before_edge", req_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", req_ready, 1);

        // delay 5 tag 3: IDLE + ARM + 3 LOAD + 5 enabled + 1 match cycle = 11 edges to FIRE
        push_req(16'd5, 4'd3);
        run_fire(-1, 16'd5, edges, en_c, rst_c, val_bad, tag);
        check("d5_latency", edges, 11);
        check("d5_tag", tag, 3);
        check("d5_en_cycles", en_c, 5);
        check("d5_rst_cycles", rst_c, 1);
        check("d5_val_stable", val_bad, 0);
        @(posedge clk);
        #1 check("d5_fire_one_cycle", fire, 0);
        check("idle_val_zero", dly_val, 0);
        check("idle_not_busy", busy, 0);

        push_req(16'd0, 4'd7);
        run_fire(-1, 16'd0, edges, en_c, rst_c, val_bad, tag);
        check("d0_latency", edges, 1);
        check("d0_tag", tag, 7);
        check("d0_no_en", en_c, 0);
        check("d0_no_rst", rst_c, 0);

        // spurious match raised during the LOAD window
        push_req(16'd3, 4'd9);
        run_fire(3, 16'd3, edges, en_c, rst_c, val_bad, tag);
        check("spur_latency", edges, 9);
        check("spur_tag", tag, 9);
        check("spur_en_cycles", en_c, 3);

        // back-to-back: the first is popped at once, so the fifth push fills the FIFO
        @(posedge clk);
        fire_q.delete();
        for (int i = 0; i < 5; i++) push_req((i == 4) ? 16'd1 : 16'(i + 1), 4'(i));
        @(negedge clk);
        check("full_ready_low", req_ready, 0);
        check("full_busy", busy, 1);
        req_valid = 1'b1; req_delay = 16'd2; req_tag = 4'd5;
        waited = 0;
        while (!req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("full_wait_cycles", waited, 5);
        waited = 0;
        while (fire_q.size() < 6 && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        check("b2b_fire_count", fire_q.size(), 6);
        for (int i = 0; i < 6; i++) check("b2b_tag_order", (i < fire_q.size()) ? fire_q[i] : 4'hx, i);

        // reset in COUNT with two requests queued
        @(posedge clk);
        fire_q.delete();
        push_req(16'd20, 4'd1);
        push_req(16'd2, 4'd2);
        push_req(16'd3, 4'd3);
        waited = 0;
        while (!dly_en && waited < 50) begin
            @(posedge clk);
            #1 waited++;
        end
        check("reach_count", dly_en, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_en", dly_en, 0);
        check("async_ready", req_ready, 0);
        check("async_busy", busy, 0);
        check("async_val", dly_val, 0);
        check("async_abort", abort_sig, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_no_fire", fire_q.size(), 0);
        check("post_rst_idle", busy, 0);
        check("post_rst_ready", req_ready, 1);

`ifdef DSP_DELAY_CTRL_TIMEOUT_EN
        // watchdog = 10 + 8: abort 18 cycles after COUNT entry
        fire_q.delete();
        stall = 1'b1;
        push_req(16'd10, 4'd1);
        push_req(16'd2, 4'd2);
        waited = 0;
        while (!dly_en && waited < 50) begin
            @(posedge clk);
            #1 waited++;
        end
        edges = 0;
        while (!abort_sig && edges < 100) begin
            @(posedge clk);
            #1 edges++;
        end
        check("abort_latency", edges, 18);
        stall = 1'b0;
        waited = 0;
        while (fire_q.size() < 1 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        check("abort_fire_count", fire_q.size(), 1);
        check("abort_next_tag", (fire_q.size() > 0) ? fire_q[0] : 4'hx, 2);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
